// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a 32x32 single-port data memory.
// Each transaction runs PRE/ACCESS/CAPTURE with done SETTLE+2 edges after the request; requesters wait, there is no queueing.
module mem_arbiter #(
  parameter int SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        mem_rst,
  output logic        mem_write_en,
  output logic        mem_mode,
  output logic [4:0]  mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, PRE, ACCESS, CAPTURE} state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        prio;
  logic        owner;
  logic        lat_we;
  logic [4:0]  lat_addr;
  logic [31:0] lat_wdata;
  logic        any_req;
  logic        win;
  logic        access_last;

  always_comb begin
    any_req     = req0 | req1;
    win         = (req0 && req1) ? prio : req1;
    access_last = (state == ACCESS) && (cnt == SETTLE_LAST);
    state_nxt   = state;
    case (state)
      IDLE:    if (any_req) state_nxt = PRE;
      PRE:     state_nxt = ACCESS;
      ACCESS:  if (cnt == SETTLE_LAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant and done decode straight from state so reset clears them in the same edge.
  always_comb begin
    gnt0         = (state != IDLE) && !owner;
    gnt1         = (state != IDLE) && owner;
    done0        = (state == CAPTURE) && !owner;
    done1        = (state == CAPTURE) && owner;
    mem_rst      = rst;
    mem_write_en = (state == ACCESS) && lat_we;
    mem_mode     = (state != ACCESS) || lat_we;
    mem_data_in  = ((state == ACCESS) && lat_we) ? lat_wdata : 32'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      prio        <= 1'b0;
      owner       <= 1'b0;
      lat_we      <= 1'b0;
      lat_addr    <= 5'd0;
      lat_wdata   <= 32'd0;
      rdata       <= 32'd0;
      mem_address <= 5'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (any_req) begin
            owner       <= win;
            prio        <= ~win;
            lat_we      <= win ? we1 : we0;
            lat_addr    <= win ? addr1 : addr0;
            lat_wdata   <= win ? wdata1 : wdata0;
            // Inverted address guarantees a change even for back-to-back same-address accesses.
            mem_address <= ~(win ? addr1 : addr0);
          end
        end
        PRE: begin
          cnt         <= 4'd0;
          mem_address <= lat_addr;
        end
        ACCESS: begin
          cnt <= access_last ? 4'd0 : cnt + 4'd1;
          if (access_last && !lat_we) rdata <= mem_data_out;
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural 32x32 memory, vector table, scoreboard of done events,
// plus arbitration, reset-abort and SETTLE=1/15 latency sequences.
module tb_mem_arbiter;
  localparam int SETTLE = 2;
  localparam int LAT    = SETTLE + 2;

  logic        clk, rst;
  logic        req0, req1, we0, we1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] rdata;
  logic        mem_rst, mem_write_en, mem_mode;
  logic [4:0]  mem_address;
  logic [31:0] mem_data_in, mem_data_out;
  logic [31:0] mem [32];

  logic        a_req, a_gnt0, a_gnt1, a_done0, a_done1, a_mrst, a_mwe, a_mmode;
  logic [31:0] a_rdata, a_mdin;
  logic [4:0]  a_maddr;
  logic        b_req, b_gnt0, b_gnt1, b_done0, b_done1, b_mrst, b_mwe, b_mmode;
  logic [31:0] b_rdata, b_mdin;
  logic [4:0]  b_maddr;
  logic [31:0] probe_data;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] rdata;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        id;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs[10];

  mem_arbiter #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
    .mem_rst(mem_rst), .mem_write_en(mem_write_en), .mem_mode(mem_mode),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  mem_arbiter #(.SETTLE(1)) dut_s1 (
    .clk(clk), .rst(rst),
    .req0(a_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(5'd9), .addr1(5'd0), .wdata0(32'd0), .wdata1(32'd0),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .done0(a_done0), .done1(a_done1), .rdata(a_rdata),
    .mem_rst(a_mrst), .mem_write_en(a_mwe), .mem_mode(a_mmode),
    .mem_address(a_maddr), .mem_data_in(a_mdin), .mem_data_out(probe_data)
  );

  mem_arbiter #(.SETTLE(15)) dut_s15 (
    .clk(clk), .rst(rst),
    .req0(b_req), .req1(1'b0), .we0(1'b0), .we1(1'b0),
    .addr0(5'd9), .addr1(5'd0), .wdata0(32'd0), .wdata1(32'd0),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
    .mem_rst(b_mrst), .mem_write_en(b_mwe), .mem_mode(b_mmode),
    .mem_address(b_maddr), .mem_data_in(b_mdin), .mem_data_out(probe_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
    end else if (mem_write_en && mem_mode) begin
      mem[mem_address] <= mem_data_in;
    end
  end
  assign mem_data_out = mem[mem_address];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always begin
    sb_t e;
    @(posedge clk);
    #1;
    if (done0 || done1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done0=%0b done1=%0b expected none at %0t", done0, done1, $time);
      end else begin
        e = sb.pop_front();
        chk("sb_done_id", {31'd0, done1}, {31'd0, e.id});
        chk("sb_rdata", rdata, e.rdata);
      end
    end
  end

  task automatic chk_reset_outputs();
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_done0", done0, 0);
    chk("rst_done1", done1, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_write_en", mem_write_en, 0);
    chk("rst_mem_mode", mem_mode, 1);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_data_in", mem_data_in, 0);
  endtask

  task automatic do_txn(input vec_t v);
    int  edges;
    bit  seen;
    logic d, g, go;
    @(negedge clk);
    if (v.id == 1'b0) begin
      req0 = 1; we0 = v.we; addr0 = v.addr; wdata0 = v.wdata;
    end else begin
      req1 = 1; we1 = v.we; addr1 = v.addr; wdata1 = v.wdata;
    end
    sb.push_back('{id: v.id, rdata: v.exp_rdata});
    edges = 0;
    seen  = 0;
    while (!seen && edges < 40) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin
        // Drop the request and scramble fields right after they were latched.
        if (v.id == 1'b0) begin
          req0 = 0; we0 = ~we0; addr0 = ~addr0; wdata0 = $urandom;
        end else begin
          req1 = 0; we1 = ~we1; addr1 = ~addr1; wdata1 = $urandom;
        end
      end
      g  = v.id ? gnt1 : gnt0;
      go = v.id ? gnt0 : gnt1;
      d  = v.id ? done1 : done0;
      chk("gnt_owner", g, 1);
      chk("gnt_other", go, 0);
      if (d) seen = 1;
    end
    if (!seen) chk("done_timeout", 0, 1);
    else chk("latency", edges, LAT);
    @(posedge clk);
    #1;
    chk("done_one_cycle", v.id ? done1 : done0, 0);
    chk("gnt_released", gnt0 | gnt1, 0);
  endtask

  initial begin
    int  cyc, last, ndone, edges, lat1, lat15;
    bit  prev_done, got1, got15;

    vecs[0] = '{1'b0, 1'b1, 5'd2, 32'd40, 32'd0};
    vecs[1] = '{1'b0, 1'b0, 5'd2, 32'd0,  32'd40};
    vecs[2] = '{1'b0, 1'b1, 5'd1, 32'd10, 32'd40};
    vecs[3] = '{1'b0, 1'b1, 5'd1, 32'd11, 32'd40};
    vecs[4] = '{1'b0, 1'b0, 5'd1, 32'd0,  32'd11};
    vecs[5] = '{1'b1, 1'b1, 5'd3, 32'd7,  32'd11};
    vecs[6] = '{1'b1, 1'b0, 5'd3, 32'd0,  32'd7};
    vecs[7] = '{1'b0, 1'b0, 5'd0, 32'd0,  32'd0};
    vecs[8] = '{1'b0, 1'b1, 5'd0, 32'd55, 32'd0};
    vecs[9] = '{1'b0, 1'b0, 5'd0, 32'd0,  32'd55};

    clk = 0; rst = 1;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    a_req = 0; b_req = 0; probe_data = 32'hA5A5_0001;

    repeat (3) @(posedge clk);
    #1;
    chk("mem_rst_follows_rst", mem_rst, 1);
    chk_reset_outputs();
    rst = 0;
    #1;
    chk("mem_rst_low", mem_rst, 0);

    for (int i = 0; i < 7; i++) do_txn(vecs[i]);

    // Both requesters held high: grants alternate starting with 0.
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 5'd2;
    req1 = 1; we1 = 0; addr1 = 5'd3;
    sb.push_back('{id: 1'b0, rdata: 32'd40});
    sb.push_back('{id: 1'b1, rdata: 32'd7});
    sb.push_back('{id: 1'b0, rdata: 32'd40});
    sb.push_back('{id: 1'b1, rdata: 32'd7});
    cyc = 0; last = 0; ndone = 0; prev_done = 0;
    while (ndone < 4 && cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      chk("gnt_exclusive", gnt0 & gnt1, 0);
      if (done0 || done1) begin
        chk("rr_done_one_cycle", prev_done, 0);
        if (ndone == 0) chk("rr_first_latency", cyc, LAT);
        else chk("rr_turnaround", cyc - last, SETTLE + 3);
        last = cyc;
        ndone++;
        if (ndone == 4) begin req0 = 0; req1 = 0; end
      end
      prev_done = done0 | done1;
    end
    if (ndone < 4) chk("rr_timeout", ndone, 4);
    @(posedge clk);
    #1;
    chk("rr_last_done_one_cycle", done0 | done1, 0);

    // Reset in the middle of a write's ACCESS phase: no done, outputs back to reset values.
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 5'd4; wdata0 = 32'd99;
    @(posedge clk);
    #1;
    req0 = 0;
    @(posedge clk);
    #1;
    chk("abort_in_access", mem_write_en, 1);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk_reset_outputs();
    repeat (8) @(posedge clk);
    #1;
    chk("abort_no_gnt", gnt0 | gnt1, 0);

    for (int i = 7; i < 10; i++) do_txn(vecs[i]);

    // SETTLE=1 and SETTLE=15 instances: request-to-done latency is SETTLE+2 edges.
    @(negedge clk);
    a_req = 1; b_req = 1;
    edges = 0; got1 = 0; got15 = 0; lat1 = 0; lat15 = 0;
    while ((!got1 || !got15) && edges < 60) begin
      @(posedge clk);
      edges++;
      #1;
      if (edges == 1) begin a_req = 0; b_req = 0; end
      if (a_done0 && !got1) begin got1 = 1; lat1 = edges; end
      if (b_done0 && !got15) begin got15 = 1; lat15 = edges; end
    end
    chk("latency_settle1", lat1, 3);
    chk("latency_settle15", lat15, 17);
    chk("rdata_settle1", a_rdata, 32'hA5A5_0001);
    chk("rdata_settle15", b_rdata, 32'hA5A5_0001);

    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
